// File: rtl/mem_pkg.sv
// mem_pkg: shared default widths, MEM-stage FSM encoding and store-buffer entry layout
package mem_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int REG_W_DEF  = 4;
    localparam int DEPTH_DEF  = 4;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: in-order circular store queue with a youngest-match address lookup
module store_buffer
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [PW:0]       count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] look_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    // pointers wrap naturally at DEPTH; count carries the extra bit to tell full from empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // entry storage, written at the tail on an accepted store
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    // scan oldest to youngest so the last (youngest) match overrides earlier ones
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && addr_q[head + PW'(i)] == look_addr) begin
                hit      = 1'b1;
                hit_data = data_q[head + PW'(i)];
            end
        end
    end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
endmodule

// File: rtl/mem_stage_sbuf.sv
// mem_stage_sbuf: MEM stage with WB store-data forwarding and a background-draining store buffer
module mem_stage_sbuf
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] WB_MemData,
    input  logic [REG_W-1:0]  WB_RegDst,
    input  logic              WB_MemToReg,
    input  logic [ADDR_W-1:0] MEM_ALUOut,
    input  logic [REG_W-1:0]  MEM_SrcReg2,
    input  logic [DATA_W-1:0] MEM_WMData,
    input  logic              MEM_StoreInstr,
    input  logic              MEM_MemToReg,
    output logic [DATA_W-1:0] MEM_MemData,
    output logic              DMEM_STALL,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [ADDR_W-1:0] DMEM_addr,
    output logic [DATA_W-1:0] DMEM_wdata,
    input  logic [DATA_W-1:0] DMEM_rdata,
    input  logic              DMEM_rdata_valid,
    input  logic              DMEM_WDONE,
    output logic              SB_EMPTY
);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] store_data;
    logic              hit;
    logic              is_load;
    logic              miss;
    logic              full;
    logic              push;
    logic              pop;
    logic              rd_done;

    // a load just finishing in WB overrides the stale register-file store data
    assign store_data = (WB_MemToReg && WB_RegDst == MEM_SrcReg2 && WB_RegDst != '0) ? WB_MemData : MEM_WMData;
    // store wins when both flags are set
    assign is_load    = MEM_MemToReg && !MEM_StoreInstr;
    assign full       = count == (PW+1)'(DEPTH);
    assign push       = MEM_StoreInstr && !full;
    assign pop        = state == WR_WAIT && DMEM_WDONE;
    assign rd_done    = state == RD_WAIT && DMEM_rdata_valid;
    assign miss       = is_load && !hit;

    store_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_addr(MEM_ALUOut),
        .push_data(store_data),
        .pop      (pop),
        .count    (count),
        .head_addr(head_addr),
        .head_data(head_data),
        .look_addr(MEM_ALUOut),
        .hit      (hit),
        .hit_data (hit_data)
    );

    // a pending load miss outranks draining; a write in flight always finishes first
    always_comb begin
        state_nx = state == IDLE    ? (miss ? RD_WAIT : (count != '0 ? WR_WAIT : IDLE)) :
                   state == RD_WAIT ? (DMEM_rdata_valid ? IDLE : RD_WAIT) :
                   state == WR_WAIT ? (DMEM_WDONE ? IDLE : WR_WAIT) : IDLE;
    end

    // reset abandons any outstanding downstream transaction
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    assign MEM_MemData = (is_load && hit) ? hit_data : rd_done ? DMEM_rdata : '0;
    assign DMEM_STALL  = (MEM_StoreInstr && full) || (miss && !rd_done);
    assign DMEM_REQ    = state != IDLE;
    assign DMEM_WE     = state == WR_WAIT;
    assign DMEM_addr   = state == RD_WAIT ? MEM_ALUOut : state == WR_WAIT ? head_addr : '0;
    assign DMEM_wdata  = state == WR_WAIT ? head_data : '0;
    assign SB_EMPTY    = count == '0 && state == IDLE;
endmodule

// File: tb/tb_mem_stage_sbuf.sv
// tb_mem_stage_sbuf: directed bench with a queue-based reference model for the store-buffered MEM stage
module tb_mem_stage_sbuf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] WB_MemData = '0;
    logic [3:0]  WB_RegDst = '0;
    logic        WB_MemToReg = 1'b0;
    logic [15:0] MEM_ALUOut = '0;
    logic [3:0]  MEM_SrcReg2 = '0;
    logic [15:0] MEM_WMData = '0;
    logic        MEM_StoreInstr = 1'b0;
    logic        MEM_MemToReg = 1'b0;
    logic [15:0] MEM_MemData;
    logic        DMEM_STALL;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [15:0] DMEM_addr;
    logic [15:0] DMEM_wdata;
    logic [15:0] DMEM_rdata = '0;
    logic        DMEM_rdata_valid = 1'b0;
    logic        DMEM_WDONE;
    logic        SB_EMPTY;
    logic        man_wdone = 1'b0;
    logic        auto_wdone = 1'b0;
    logic        auto_wr = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    assign DMEM_WDONE = man_wdone | auto_wdone;

    mem_stage_sbuf dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .WB_MemData      (WB_MemData),
        .WB_RegDst       (WB_RegDst),
        .WB_MemToReg     (WB_MemToReg),
        .MEM_ALUOut      (MEM_ALUOut),
        .MEM_SrcReg2     (MEM_SrcReg2),
        .MEM_WMData      (MEM_WMData),
        .MEM_StoreInstr  (MEM_StoreInstr),
        .MEM_MemToReg    (MEM_MemToReg),
        .MEM_MemData     (MEM_MemData),
        .DMEM_STALL      (DMEM_STALL),
        .DMEM_REQ        (DMEM_REQ),
        .DMEM_WE         (DMEM_WE),
        .DMEM_addr       (DMEM_addr),
        .DMEM_wdata      (DMEM_wdata),
        .DMEM_rdata      (DMEM_rdata),
        .DMEM_rdata_valid(DMEM_rdata_valid),
        .DMEM_WDONE      (DMEM_WDONE),
        .SB_EMPTY        (SB_EMPTY)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: pending stores as a queue (front = oldest), plus what the port is busy with
    typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
    ent_t m_q[$];
    int   m_port = 0;
    bit   m_ok = 1'b0;

    function automatic void lookup(output logic h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
        foreach (m_q[i]) if (m_q[i].a == MEM_ALUOut) begin h = 1'b1; d = m_q[i].d; end
    endfunction

    function automatic logic [15:0] fwd_data();
        return (WB_MemToReg && WB_RegDst == MEM_SrcReg2 && WB_RegDst != 0) ? WB_MemData : MEM_WMData;
    endfunction

    function automatic logic [15:0] e_data();
        logic h;
        logic [15:0] d;
        lookup(h, d);
        if (MEM_MemToReg && !MEM_StoreInstr && h) return d;
        return (m_port == 1 && DMEM_rdata_valid) ? DMEM_rdata : 16'h0;
    endfunction

    function automatic logic e_stall();
        logic h;
        logic [15:0] d;
        lookup(h, d);
        if (MEM_StoreInstr) return m_q.size() == 4;
        return MEM_MemToReg && !h && !(m_port == 1 && DMEM_rdata_valid);
    endfunction

    function automatic int next_port();
        logic h;
        logic [15:0] d;
        lookup(h, d);
        if (m_port == 1) return DMEM_rdata_valid ? 0 : 1;
        if (m_port == 2) return DMEM_WDONE ? 0 : 2;
        if (MEM_MemToReg && !MEM_StoreInstr && !h) return 1;
        return m_q.size() > 0 ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_port <= 0;
            m_ok   <= 1'b1;
        end else if (m_ok) begin
            m_port <= next_port();
            if (MEM_StoreInstr && m_q.size() < 4) m_q.push_back('{MEM_ALUOut, fwd_data()});
            if (m_port == 2 && DMEM_WDONE) void'(m_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_data", MEM_MemData, e_data());
            chk("cyc_stall", DMEM_STALL, e_stall());
            chk("cyc_req", DMEM_REQ, m_port != 0);
            chk("cyc_we", DMEM_WE, m_port == 2);
            chk("cyc_addr", DMEM_addr, m_port == 1 ? MEM_ALUOut : m_port == 2 ? m_q[0].a : 16'h0);
            chk("cyc_wdata", DMEM_wdata, m_port == 2 ? m_q[0].d : 16'h0);
            chk("cyc_empty", SB_EMPTY, m_q.size() == 0 && m_port == 0);
        end
    end

    logic [31:0] wr_log[$];
    always @(posedge clk) if (rst_n && DMEM_REQ && DMEM_WE && DMEM_WDONE) wr_log.push_back({DMEM_addr, DMEM_wdata});

    // background write responder: WDONE high every other cycle while enabled
    always @(posedge clk) auto_wdone <= auto_wr && !auto_wdone;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [15:0] a, input logic [15:0] d, input logic [3:0] s);
        int n = 0;
        MEM_StoreInstr = 1'b1;
        MEM_MemToReg   = 1'b0;
        MEM_ALUOut     = a;
        MEM_WMData     = d;
        MEM_SrcReg2    = s;
        #1;
        while (DMEM_STALL && n < 200) begin step(); n++; end
        if (n == 200) chk("store_timeout", n, 0);
        step();
        MEM_StoreInstr = 1'b0;
    endtask

    task automatic wait_wr();
        int n = 0;
        while (!(DMEM_REQ && DMEM_WE) && n < 20) begin step(); n++; end
        chk("wr_issue_timeout", n < 20, 1);
    endtask

    task automatic drain();
        int n = 0;
        auto_wr = 1'b1;
        while (!SB_EMPTY && n < 100) begin step(); n++; end
        chk("drain_timeout", n < 100, 1);
        auto_wr = 1'b0;
        step();
    endtask

    initial begin
        int n;
        // reset state
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_empty", SB_EMPTY, 1);
        chk("rst_req", DMEM_REQ, 0);
        chk("rst_stall", DMEM_STALL, 0);
        chk("rst_data", MEM_MemData, 0);
        // reset while a write is outstanding with three entries buffered
        put_store(16'h0001, 16'h1111, 0);
        put_store(16'h0002, 16'h2222, 0);
        put_store(16'h0003, 16'h3333, 0);
        chk("t1_wr_pending", {DMEM_REQ, DMEM_WE}, 2'b11);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("t1_req", DMEM_REQ, 0);
        chk("t1_empty", SB_EMPTY, 1);
        chk("t1_stall", DMEM_STALL, 0);
        man_wdone = 1'b1;
        step();
        man_wdone = 1'b0;
        #1;
        chk("t1_late_wdone_empty", SB_EMPTY, 1);
        chk("t1_late_wdone_req", DMEM_REQ, 0);
        // youngest-match forwarding with the drain held off
        put_store(16'h0010, 16'hAAAA, 0);
        put_store(16'h0010, 16'hBBBB, 0);
        MEM_MemToReg = 1'b1;
        MEM_ALUOut   = 16'h0010;
        #1;
        chk("t2_hit_data", MEM_MemData, 16'hBBBB);
        chk("t2_hit_stall", DMEM_STALL, 0);
        chk("t2_no_read", DMEM_WE, 1);
        step();
        MEM_MemToReg = 1'b0;
        drain();
        // load miss waits for the in-flight write, then reads
        put_store(16'h0030, 16'h7777, 0);
        step();
        MEM_MemToReg = 1'b1;
        MEM_ALUOut   = 16'h0020;
        #1;
        chk("t3_miss_stall", DMEM_STALL, 1);
        chk("t3_wr_first", DMEM_WE, 1);
        man_wdone = 1'b1;
        step();
        man_wdone = 1'b0;
        n = 0;
        while (!(DMEM_REQ && !DMEM_WE) && n < 20) begin step(); n++; end
        chk("t3_rd_issue", {DMEM_REQ, DMEM_WE}, 2'b10);
        chk("t3_rd_addr", DMEM_addr, 16'h0020);
        chk("t3_stall_wait", DMEM_STALL, 1);
        DMEM_rdata       = 16'h1234;
        DMEM_rdata_valid = 1'b1;
        #1;
        chk("t3_rd_data", MEM_MemData, 16'h1234);
        chk("t3_rd_stall", DMEM_STALL, 0);
        step();
        DMEM_rdata_valid = 1'b0;
        MEM_MemToReg     = 1'b0;
        #1;
        chk("t3_done_empty", SB_EMPTY, 1);
        chk("t3_done_data", MEM_MemData, 0);
        // full buffer stalls the fifth store until the cycle after the first WDONE
        wr_log.delete();
        for (int i = 0; i < 4; i++) put_store(16'h0050 + 16'(i), 16'hC000 + 16'(i), 0);
        MEM_StoreInstr = 1'b1;
        MEM_ALUOut     = 16'h0054;
        MEM_WMData     = 16'hC004;
        MEM_SrcReg2    = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_full_stall", DMEM_STALL, 1);
            step();
        end
        man_wdone = 1'b1;
        #1;
        chk("t4_stall_on_wdone", DMEM_STALL, 1);
        step();
        man_wdone = 1'b0;
        #1;
        chk("t4_release", DMEM_STALL, 0);
        step();
        MEM_StoreInstr = 1'b0;
        drain();
        chk("t4_writes", wr_log.size(), 5);
        chk("t4_fifth", wr_log.size() > 0 ? wr_log[$] : 32'h0, {16'h0054, 16'hC004});
        // WB-to-MEM store data forwarding
        WB_MemToReg = 1'b1;
        WB_RegDst   = 4'd5;
        WB_MemData  = 16'h5555;
        put_store(16'h0060, 16'h0000, 4'd5);
        wait_wr();
        chk("t5_fwd_r5", DMEM_wdata, 16'h5555);
        drain();
        WB_RegDst = 4'd0;
        put_store(16'h0061, 16'h0000, 4'd0);
        wait_wr();
        chk("t5_no_fwd_r0", DMEM_wdata, 16'h0000);
        drain();
        WB_RegDst = 4'd6;
        put_store(16'h0062, 16'h6666, 4'd5);
        wait_wr();
        chk("t5_no_fwd_other", DMEM_wdata, 16'h6666);
        drain();
        WB_MemToReg = 1'b0;
        // eight stores with background drain: pointer wrap and write order
        wr_log.delete();
        auto_wr = 1'b1;
        for (int i = 0; i < 8; i++) put_store(16'h0100 + 16'(i), 16'hD000 + 16'(i), 0);
        drain();
        chk("t6_count", wr_log.size(), 8);
        for (int i = 0; i < wr_log.size() && i < 8; i++) chk("t6_order", wr_log[i], {16'h0100 + 16'(i), 16'hD000 + 16'(i)});
        chk("t6_empty", SB_EMPTY, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
